// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - Handshaked WIDTH-bit ALU with MUL high half and optional iterative divider (ALU_DIV_EN)
module alu_pipe #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_fun,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] alu_out_hi,
    output logic             c_out,
    output logic             arith_flag,
    output logic             logic_flag,
    output logic             cmp_flag,
    output logic             shift_flag,
    output logic             div0_flag
);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_HOLD} state_t;

    state_t state;
    logic   rst_done;
    logic   accept;

    // rst_done keeps in_ready low until the first clock after reset release
    assign in_ready  = rst_done && (state == S_IDLE || (state == S_HOLD && out_ready));
    assign out_valid = (state == S_HOLD);
    assign accept    = in_valid && in_ready;

    logic [WIDTH-1:0]   r_lo, r_hi;
    logic               r_c, r_div0, r_start_div;
    logic [3:0]         r_cls;
    logic [WIDTH:0]     sum, shr_w, shl_w;
    logic [2*WIDTH-1:0] prod;
    logic [SHAMT_W-1:0] amt;
    logic               big;

    assign sum   = {1'b0, a} + {1'b0, b};
    assign prod  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign amt   = b[SHAMT_W-1:0];
    assign big   = 32'(amt) >= 32'(WIDTH);
    // The extra bit beside a catches the last bit shifted out
    assign shr_w = {a, 1'b0} >> amt;
    assign shl_w = {1'b0, a} << amt;

    always_comb begin
        r_lo        = '0;
        r_hi        = '0;
        r_c         = 1'b0;
        r_div0      = 1'b0;
        r_start_div = 1'b0;
        r_cls       = 4'b0000;
        case (alu_fun)
            4'd0:  begin r_lo = sum[WIDTH-1:0]; r_c = sum[WIDTH]; r_cls = 4'b1000; end
            4'd1:  begin r_lo = a - b; r_c = (a < b); r_cls = 4'b1000; end
            4'd2:  begin r_lo = prod[WIDTH-1:0]; r_hi = prod[2*WIDTH-1:WIDTH]; r_cls = 4'b1000; end
            4'd3: begin
                r_cls = 4'b1000;
`ifdef ALU_DIV_EN
                if (b == '0) begin
                    r_lo   = '1;
                    r_hi   = a;
                    r_div0 = 1'b1;
                end else begin
                    r_start_div = 1'b1;
                end
`else
                r_div0 = 1'b1;
`endif
            end
            4'd4:  begin r_lo = a & b;    r_cls = 4'b0100; end
            4'd5:  begin r_lo = a | b;    r_cls = 4'b0100; end
            4'd6:  begin r_lo = ~(a & b); r_cls = 4'b0100; end
            4'd7:  begin r_lo = ~(a | b); r_cls = 4'b0100; end
            4'd8:  begin r_lo = a ^ b;    r_cls = 4'b0100; end
            4'd9:  begin r_lo = ~(a ^ b); r_cls = 4'b0100; end
            4'd10: begin r_lo = {{(WIDTH-1){1'b0}}, a == b}; r_cls = 4'b0010; end
            4'd11: begin r_lo = {{(WIDTH-1){1'b0}}, a > b};  r_cls = 4'b0010; end
            4'd12: begin r_lo = {{(WIDTH-1){1'b0}}, a < b};  r_cls = 4'b0010; end
            4'd13: begin
                r_cls = 4'b0001;
                if (!big) begin r_lo = shr_w[WIDTH:1]; r_c = shr_w[0]; end
            end
            4'd14: begin
                r_cls = 4'b0001;
                if (!big) begin r_lo = shl_w[WIDTH-1:0]; r_c = shl_w[WIDTH]; end
            end
            default: ;
        endcase
    end

`ifdef ALU_DIV_EN
    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] div_rem, div_quo, div_dvsr, rem_n, quo_n;
    logic [CNT_W-1:0] div_cnt;
    logic [WIDTH:0]   rem_sh;
    logic             div_ge;

    // Restoring step: dividend bits stream out of div_quo's MSB while quotient bits enter its LSB
    assign rem_sh = {div_rem, div_quo[WIDTH-1]};
    assign div_ge = rem_sh >= {1'b0, div_dvsr};
    assign rem_n  = div_ge ? WIDTH'(rem_sh - {1'b0, div_dvsr}) : rem_sh[WIDTH-1:0];
    assign quo_n  = {div_quo[WIDTH-2:0], div_ge};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rst_done   <= 1'b0;
            alu_out    <= '0;
            alu_out_hi <= '0;
            c_out      <= 1'b0;
            arith_flag <= 1'b0;
            logic_flag <= 1'b0;
            cmp_flag   <= 1'b0;
            shift_flag <= 1'b0;
            div0_flag  <= 1'b0;
`ifdef ALU_DIV_EN
            div_rem    <= '0;
            div_quo    <= '0;
            div_dvsr   <= '0;
            div_cnt    <= '0;
`endif
        end else begin
            rst_done <= 1'b1;
            if (accept) begin
                if (r_start_div) begin
`ifdef ALU_DIV_EN
                    state    <= S_DIV;
                    div_rem  <= '0;
                    div_quo  <= a;
                    div_dvsr <= b;
                    div_cnt  <= '0;
`endif
                end else begin
                    state      <= S_HOLD;
                    alu_out    <= r_lo;
                    alu_out_hi <= r_hi;
                    c_out      <= r_c;
                    {arith_flag, logic_flag, cmp_flag, shift_flag} <= r_cls;
                    div0_flag  <= r_div0;
                end
            end else if (state == S_HOLD && out_ready) begin
                state <= S_IDLE;
            end
`ifdef ALU_DIV_EN
            else if (state == S_DIV) begin
                div_rem <= rem_n;
                div_quo <= quo_n;
                div_cnt <= div_cnt + 1'b1;
                if (div_cnt == CNT_W'(WIDTH-1)) begin
                    state      <= S_HOLD;
                    alu_out    <= quo_n;
                    alu_out_hi <= rem_n;
                    c_out      <= 1'b0;
                    {arith_flag, logic_flag, cmp_flag, shift_flag} <= 4'b1000;
                    div0_flag  <= 1'b0;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - Directed self-checking bench for alu_pipe (WIDTH=16)
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, alu_out, alu_out_hi;
    logic [3:0]  alu_fun;
    logic        c_out, arith_flag, logic_flag, cmp_flag, shift_flag, div0_flag;
    logic [6:0]  st;
    int          total = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(16), .SHAMT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .alu_fun(alu_fun), .out_valid(out_valid), .out_ready(out_ready),
        .alu_out(alu_out), .alu_out_hi(alu_out_hi), .c_out(c_out),
        .arith_flag(arith_flag), .logic_flag(logic_flag), .cmp_flag(cmp_flag),
        .shift_flag(shift_flag), .div0_flag(div0_flag)
    );

    // {out_valid, arith, logic, cmp, shift, div0, c_out}
    assign st = {out_valid, arith_flag, logic_flag, cmp_flag, shift_flag, div0_flag, c_out};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic do_op(input logic [3:0] f, input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        in_valid = 1'b1;
        alu_fun  = f;
        a        = x;
        b        = y;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic one(input string tag, input logic [3:0] f, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] lo, input logic [15:0] hi, input logic [6:0] s);
        do_op(f, x, y);
        chk({tag, ".lo"}, 64'(alu_out), 64'(lo));
        chk({tag, ".hi"}, 64'(alu_out_hi), 64'(hi));
        chk({tag, ".st"}, 64'(st), 64'(s));
    endtask

    initial begin
        int  lat;
        logic seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; alu_fun = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready", 64'(in_ready), 64'd0);
        chk("rst.outs", {25'd0, alu_out, alu_out_hi, st}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel.in_ready", 64'(in_ready), 64'd1);
        chk("rel.out_valid", 64'(out_valid), 64'd0);

        one("add",  4'd0,  16'd20, 16'd15, 16'd35,     16'd0, 7'b1100000);
        one("sub",  4'd1,  16'd20, 16'd15, 16'd5,      16'd0, 7'b1100000);
        one("mul",  4'd2,  16'd20, 16'd15, 16'd300,    16'd0, 7'b1100000);
        one("and",  4'd4,  16'd20, 16'd15, 16'd4,      16'd0, 7'b1010000);
        one("or",   4'd5,  16'd20, 16'd15, 16'd31,     16'd0, 7'b1010000);
        one("nand", 4'd6,  16'd20, 16'd15, 16'hFFFB,   16'd0, 7'b1010000);
        one("nor",  4'd7,  16'd20, 16'd15, 16'hFFE0,   16'd0, 7'b1010000);
        one("xor",  4'd8,  16'd20, 16'd15, 16'd27,     16'd0, 7'b1010000);
        one("xnor", 4'd9,  16'd20, 16'd15, 16'hFFE4,   16'd0, 7'b1010000);
        one("eq",   4'd10, 16'd20, 16'd15, 16'd0,      16'd0, 7'b1001000);
        one("gt",   4'd11, 16'd20, 16'd15, 16'd1,      16'd0, 7'b1001000);
        one("lt",   4'd12, 16'd20, 16'd15, 16'd0,      16'd0, 7'b1001000);
        one("shr",  4'd13, 16'd20, 16'd15, 16'd0,      16'd0, 7'b1000100);
        one("shl",  4'd14, 16'd20, 16'd15, 16'd0,      16'd0, 7'b1000100);
        one("nop",  4'd15, 16'd20, 16'd15, 16'd0,      16'd0, 7'b1000000);

        one("eq2",  4'd10, 16'd5, 16'd10, 16'd0,       16'd0, 7'b1001000);
        one("gt2",  4'd11, 16'd5, 16'd10, 16'd0,       16'd0, 7'b1001000);
        one("lt2",  4'd12, 16'd5, 16'd10, 16'd1,       16'd0, 7'b1001000);
        one("sub2", 4'd1,  16'd5, 16'd10, 16'hFFFB,    16'd0, 7'b1100001);
        one("eq3",  4'd10, 16'd3, 16'd3,  16'd1,       16'd0, 7'b1001000);
        one("gt3",  4'd11, 16'd3, 16'd3,  16'd0,       16'd0, 7'b1001000);
        one("lt3",  4'd12, 16'd3, 16'd3,  16'd0,       16'd0, 7'b1001000);
        one("addc", 4'd0,  16'hFFFF, 16'd1, 16'd0,     16'd0, 7'b1100001);
        one("shr1", 4'd13, 16'h8001, 16'd1, 16'h4000,  16'd0, 7'b1000101);
        one("shl1", 4'd14, 16'h8001, 16'd1, 16'h0002,  16'd0, 7'b1000101);
        one("mulx", 4'd2,  16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 7'b1100000);

`ifdef ALU_DIV_EN
        @(negedge clk);
        in_valid = 1'b1; alu_fun = 4'd3; a = 16'd100; b = 16'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat  = 1;
        seen = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready) seen = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        chk("div.latency", 64'(lat), 64'd17);
        chk("div.in_ready_low", 64'(seen), 64'd0);
        chk("div.lo", 64'(alu_out), 64'd14);
        chk("div.hi", 64'(alu_out_hi), 64'd2);
        chk("div.st", 64'(st), 64'b1100000);
        one("div0", 4'd3, 16'd9, 16'd0, 16'hFFFF, 16'd9, 7'b1100010);
`else
        one("div_off", 4'd3, 16'd100, 16'd7, 16'd0, 16'd0, 7'b1100010);
        one("div_off0", 4'd3, 16'd9, 16'd0, 16'd0, 16'd0, 7'b1100010);
`endif

        one("bp.add", 4'd0, 16'd1000, 16'd234, 16'd1234, 16'd0, 7'b1100000);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp.hold_lo", 64'(alu_out), 64'd1234);
            chk("bp.hold_st", 64'(st), 64'b1100000);
            chk("bp.in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; alu_fun = 4'd1; a = 16'd50; b = 16'd8;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp.next_lo", 64'(alu_out), 64'd42);
        chk("bp.next_st", 64'(st), 64'b1100000);
        @(posedge clk);
        #1;
        chk("bp.no_dup", 64'(out_valid), 64'd0);

`ifdef ALU_DIV_EN
        do_op(4'd3, 16'd100, 16'd7);
        repeat (7) @(posedge clk);
`else
        do_op(4'd0, 16'd1, 16'd2);
        out_ready = 1'b0;
        @(posedge clk);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.outs", {25'd0, alu_out, alu_out_hi, st}, 64'd0);
        chk("arst.in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("arst.rel_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("arst.no_stale", 64'(seen), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
